// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcodes and datapath mux-select values.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    ADDR   = 4'd2,
    MEM    = 4'd3,
    EXEC_R = 4'd4,
    EXEC_I = 4'd5,
    WB_ALU = 4'd6,
    WB_MEM = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    TRAP   = 4'd10,
    ERR    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_TRAP   = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WBS_ALU = 2'd0;
  localparam logic [1:0] WBS_MEM = 2'd1;
  localparam logic [1:0] WBS_PC  = 2'd2;

  localparam logic [1:0] ALUB_RDATA2  = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait counter: counts stalled cycles and flags when MAX_WAIT is reached.
module mc_wait_timer #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if (clear)
      wait_cnt <= '0;
    else if (count && !expired)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign expired = (wait_cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM sharing one memory port with bounded wait.
// Define MC_TRAP_EN to trap illegal opcodes; otherwise they retire as NOPs.
module multi_cycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             err,
  output logic             trap,
  output logic [3:0]       state
);

  state_t state_q, state_d;
  logic   wait_count, expired;

  // funct is decoded by the ALU control, not here
  logic unused_funct;
  assign unused_funct = ^funct;

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wait_timer (
    .clk    (CLK),
    .rst_n  (RST),
    .clear  (!wait_count),
    .count  (wait_count),
    .expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    wait_count = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    reg_we     = 1'b0;
    reg_dst    = RD_RT;
    wb_src     = WBS_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_RDATA2;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ALUB_FOUR;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end else begin
          wait_count = 1'b1;
          if (expired) state_d = ERR;
        end
      end
      DECODE: begin
        alu_src_b = ALUB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:   state_d = ADDR;
          OP_RTYPE:       state_d = EXEC_R;
          OP_ADDI:        state_d = EXEC_I;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J, OP_JAL:   state_d = JUMP;
          default: begin
`ifdef MC_TRAP_EN
            state_d = TRAP;
`else
            instr_done = 1'b1;
            state_d    = FETCH;
`endif
          end
        endcase
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = MEM;
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_LW) begin
            state_d = WB_MEM;
          end else begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end else begin
          wait_count = 1'b1;
          if (expired) state_d = ERR;
        end
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = WB_ALU;
      end
      WB_ALU: begin
        reg_we     = 1'b1;
        reg_dst    = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      WB_MEM: begin
        reg_we     = 1'b1;
        wb_src     = WBS_MEM;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_src     = PC_BRANCH;
        pc_we      = zero ^ (opcode == OP_BNE);
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pc_we  = 1'b1;
        pc_src = PC_JUMP;
        if (opcode == OP_JAL) begin
          reg_we  = 1'b1;
          reg_dst = RD_RA;
          wb_src  = WBS_PC;
        end
        instr_done = 1'b1;
        state_d    = FETCH;
      end
`ifdef MC_TRAP_EN
      TRAP: begin
        trap    = 1'b1;
        pc_we   = 1'b1;
        pc_src  = PC_TRAP;
        state_d = FETCH;
      end
`endif
      ERR:     state_d = ERR;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= FETCH;
      retired <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_done) retired <= retired + 1'b1;
      if (state_d == ERR) err <= 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl (4-bit retired counter).
module tb_multi_cycle_ctrl;
  import mc_pkg::*;

  logic       CLK, RST;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_src_a;
  logic [1:0] pc_src, reg_dst, wb_src, alu_src_b, alu_op;
  logic       instr_done, err, trap;
  logic [3:0] retired;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multi_cycle_ctrl #(.CNT_W(4), .MAX_WAIT(15), .WAIT_W(4)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_src(wb_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .retired(retired), .err(err), .trap(trap), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (retired !== 4'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    tick();
    RST = 1'b1;
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [5];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
    do_reset();
    opcode = OP_LW; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL lw_state%0d: got %0d expected %0d", i, state, exp_st[i]); end
      if (i == 0) begin
        checks++; if ({mem_req, iord, ir_we, pc_we, alu_src_b} !== 6'b101101) begin errors++; $display("FAIL lw_fetch_ctl: got %b expected 101101", {mem_req, iord, ir_we, pc_we, alu_src_b}); end
      end
      if (i == 3) begin
        checks++; if ({mem_req, iord, mem_we} !== 3'b110) begin errors++; $display("FAIL lw_mem_ctl: got %b expected 110", {mem_req, iord, mem_we}); end
      end
      if (i == 4) begin
        checks++; if ({reg_we, wb_src, reg_dst, instr_done} !== 6'b101001) begin errors++; $display("FAIL lw_wb_ctl: got %b expected 101001", {reg_we, wb_src, reg_dst, instr_done}); end
      end
      tick();
    end
    checks++; if (retired !== 4'd1) begin errors++; $display("FAIL lw_retired: got %0d expected 1", retired); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_end_state: got %0d expected 0", state); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [3];
    logic       zs  [3];
    logic       pcw [3];
    ops = '{OP_BEQ, OP_BEQ, OP_BNE};
    zs  = '{1'b1, 1'b0, 1'b0};
    pcw = '{1'b1, 1'b0, 1'b1};
    do_reset();
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k]; zero = zs[k];
      #1;
      tick();
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL br%0d_decode: got %0d expected 1", k, state); end
      tick();
      checks++; if (state !== 4'd8) begin errors++; $display("FAIL br%0d_state: got %0d expected 8", k, state); end
      checks++; if ({pc_we, pc_src, alu_op, instr_done} !== {pcw[k], 2'd1, 2'd1, 1'b1}) begin
        errors++; $display("FAIL br%0d_ctl: got %b expected %b", k, {pc_we, pc_src, alu_op, instr_done}, {pcw[k], 2'd1, 2'd1, 1'b1});
      end
      tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL br%0d_end: got %0d expected 0", k, state); end
    end
    checks++; if (retired !== 4'd3) begin errors++; $display("FAIL br_retired: got %0d expected 3", retired); end
    zero = 1'b0;
  endtask

  task automatic test_jal_rtype();
    do_reset();
    mem_ready = 1'b1; opcode = OP_JAL;
    tick(); tick();
    checks++; if (state !== 4'd9) begin errors++; $display("FAIL jal_state: got %0d expected 9", state); end
    checks++; if ({pc_we, pc_src, reg_we, reg_dst, wb_src} !== 8'b1_10_1_10_10) begin
      errors++; $display("FAIL jal_ctl: got %b expected 11011010", {pc_we, pc_src, reg_we, reg_dst, wb_src});
    end
    tick();
    opcode = OP_RTYPE;
    tick(); tick();
    checks++; if ({state, alu_src_a, alu_src_b, alu_op} !== {4'd4, 1'b1, 2'd0, 2'd2}) begin
      errors++; $display("FAIL rtype_exec: got %b expected %b", {state, alu_src_a, alu_src_b, alu_op}, {4'd4, 1'b1, 2'd0, 2'd2});
    end
    tick();
    checks++; if ({state, reg_we, reg_dst, wb_src, instr_done} !== {4'd6, 1'b1, 2'd1, 2'd0, 1'b1}) begin
      errors++; $display("FAIL rtype_wb: got %b expected %b", {state, reg_we, reg_dst, wb_src, instr_done}, {4'd6, 1'b1, 2'd1, 2'd0, 1'b1});
    end
    tick();
    opcode = OP_ADDI;
    tick(); tick();
    checks++; if ({state, alu_src_b} !== {4'd5, 2'd2}) begin errors++; $display("FAIL addi_exec: got %b expected %b", {state, alu_src_b}, {4'd5, 2'd2}); end
    tick();
    checks++; if ({state, reg_we, reg_dst} !== {4'd6, 1'b1, 2'd0}) begin errors++; $display("FAIL addi_wb: got %b expected %b", {state, reg_we, reg_dst}, {4'd6, 1'b1, 2'd0}); end
    tick();
    checks++; if (retired !== 4'd3) begin errors++; $display("FAIL jal_rtype_retired: got %0d expected 3", retired); end
  endtask

  task automatic test_sw_wait();
    do_reset();
    opcode = OP_SW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      checks++; if ({state, mem_we, err, instr_done} !== {4'd3, 1'b1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL sw_wait%0d: got %b expected %b", i, {state, mem_we, err, instr_done}, {4'd3, 1'b1, 1'b0, 1'b0});
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if ({state, mem_we, instr_done} !== {4'd3, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sw_accept: got %b expected %b", {state, mem_we, instr_done}, {4'd3, 1'b1, 1'b1});
    end
    tick();
    checks++; if ({state, err, retired} !== {4'd0, 1'b0, 4'd1}) begin
      errors++; $display("FAIL sw_done: got %b expected %b", {state, err, retired}, {4'd0, 1'b0, 4'd1});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = OP_SW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if ({state, err} !== {4'd3, 1'b0}) begin errors++; $display("FAIL to_wait%0d: got %b expected %b", i, {state, err}, {4'd3, 1'b0}); end
      tick();
    end
    checks++; if ({state, err} !== {4'd11, 1'b1}) begin errors++; $display("FAIL to_err: got %b expected %b", {state, err}, {4'd11, 1'b1}); end
    mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if ({state, err, mem_req, pc_we, reg_we, ir_we} !== {4'd11, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL to_hold: got %b expected %b", {state, err, mem_req, pc_we, reg_we, ir_we}, {4'd11, 1'b1, 4'b0000});
    end
    #2 RST = 1'b0;
    #1;
    checks++; if ({state, err} !== {4'd0, 1'b0}) begin errors++; $display("FAIL to_reset: got %b expected %b", {state, err}, {4'd0, 1'b0}); end
    tick();
    RST = 1'b1;
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'h3F; mem_ready = 1'b1;
    tick();
`ifdef MC_TRAP_EN
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL ill_decode_done: got %b expected 0", instr_done); end
    tick();
    checks++; if ({state, trap, pc_we, pc_src} !== {4'd10, 1'b1, 1'b1, 2'd3}) begin
      errors++; $display("FAIL ill_trap: got %b expected %b", {state, trap, pc_we, pc_src}, {4'd10, 1'b1, 1'b1, 2'd3});
    end
    tick();
    checks++; if ({state, retired} !== {4'd0, 4'd0}) begin errors++; $display("FAIL ill_after: got %b expected %b", {state, retired}, {4'd0, 4'd0}); end
`else
    checks++; if ({state, instr_done, trap} !== {4'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ill_nop: got %b expected %b", {state, instr_done, trap}, {4'd1, 1'b1, 1'b0});
    end
    tick();
    checks++; if ({state, retired} !== {4'd0, 4'd1}) begin errors++; $display("FAIL ill_after: got %b expected %b", {state, retired}, {4'd0, 4'd1}); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ret;
    do_reset();
    opcode = OP_J; mem_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick(); tick(); tick();
      exp_ret = 4'(i % 16);
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL wrap%0d: got %0d expected %0d", i, retired, exp_ret); end
    end
    tick(); tick(); tick();
    opcode = OP_LW;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    checks++; if ({state, retired} !== {4'd3, 4'd1}) begin errors++; $display("FAIL midmem_pre: got %b expected %b", {state, retired}, {4'd3, 4'd1}); end
    #2 RST = 1'b0;
    #1;
    checks++; if ({state, retired} !== {4'd0, 4'd0}) begin errors++; $display("FAIL midmem_reset: got %b expected %b", {state, retired}, {4'd0, 4'd0}); end
    tick();
    RST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_branch();
    test_jal_rtype();
    test_sw_wait();
    test_timeout();
    test_illegal();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
